shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_serializer_bit_counter.sv | 27 ++
 rtl/shift_serializer.sv | 88 ++++++++
 tb/tb_shift_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state type and counter sizing for the serializer
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-index counter width for a word of w bits (w >= 2).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_serializer_bit_counter.sv
// rtl/shift_serializer_bit_counter.sv - per-word bit index counter
module bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        inc,
  output logic [cnt_width(WIDTH)-1:0] count
);

  localparam int CW = cnt_width(WIDTH);

  // Clear has priority over increment so a reload or word end never wraps the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - parallel-to-serial shifter with gapless reload
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             q,
  output logic             q_valid,
  output logic             done
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    count;
  logic             last;
  logic             advance;
  logic             load;
  logic             cnt_clr;
  logic             cnt_inc;

  assign last    = (state == SHIFT) && (count == LAST_CNT);
  assign advance = (state == SHIFT) && shift_en;

  // Ready in IDLE, or in the cycle the final bit leaves so the next word follows without a gap.
  assign load_ready = (state == IDLE) || (last && shift_en);
  assign load       = load_valid && load_ready;
  assign done       = last && shift_en;
  assign q_valid    = (state == SHIFT);

  // Output bit taken straight from the register end facing the consumer.
  assign q = (state != SHIFT) ? 1'b0 :
             (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  // Counter restarts on every load and at word end; otherwise it counts consumed bits.
  assign cnt_clr = load || (last && shift_en);
  assign cnt_inc = advance && !last;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count)
  );

  // Next-state and next-shift-register: load wins over shift, word end without load returns to IDLE.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    if (advance) begin
      if (MSB_FIRST != 0) begin
        shreg_d = {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg[WIDTH-1:1]};
      end
    end
    if (load) begin
      shreg_d = din;
      state_d = SHIFT;
    end else if (last && shift_en) begin
      state_d = IDLE;
    end
  end

  // State and shift register; reset overrides any load or shift in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// tb/tb_shift_serializer.sv - self-checking bench for shift_serializer
module tb_shift_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din;
  logic       lv [3];
  logic       se [3];
  logic       lr [3];
  logic       qo [3];
  logic       qv [3];
  logic       dn [3];

  shift_serializer #(.WIDTH(4), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .din(din[3:0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .shift_en(se[0]), .q(qo[0]), .q_valid(qv[0]), .done(dn[0]));
  shift_serializer #(.WIDTH(4), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset(reset), .din(din[3:0]), .load_valid(lv[1]), .load_ready(lr[1]),
    .shift_en(se[1]), .q(qo[1]), .q_valid(qv[1]), .done(dn[1]));
  shift_serializer #(.WIDTH(8), .MSB_FIRST(1)) u2 (
    .clk(clk), .reset(reset), .din(din), .load_valid(lv[2]), .load_ready(lr[2]),
    .shift_en(se[2]), .q(qo[2]), .q_valid(qv[2]), .done(dn[2]));

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  // Model: word being sent and number of bits still to be consumed.
  int         mw   [3] = '{4, 4, 8};
  int         mmsb [3] = '{1, 0, 1};
  logic [7:0] mword[3];
  int         left [3] = '{0, 0, 0};

  // Captured serial stream of consumed bits, per instance.
  logic [15:0] cap  [3];
  int          ncap [3];
  int          ndone[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_ready(input int i);
    return (left[i] == 0) || (left[i] == 1 && se[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        left[i] = 0;
      end else begin
        bit rdy;
        rdy = m_ready(i);
        if (se[i] && left[i] > 0) left[i] = left[i] - 1;
        if (lv[i] && rdy) begin
          mword[i] = din;
          left[i]  = mw[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [3:0] expv;
        logic [3:0] actv;
        logic       ebit;
        int         idx;
        idx  = (mmsb[i] != 0) ? left[i] - 1 : mw[i] - left[i];
        ebit = (left[i] > 0) ? mword[i][idx] : 1'b0;
        expv = {left[i] > 0, ebit, (left[i] == 1) && se[i], m_ready(i)};
        actv = {qv[i], qo[i], dn[i], lr[i]};
        check($sformatf("u%0d_qv_q_done_ready", i), 32'(actv), 32'(expv));
        if (qv[i] && se[i]) begin
          cap[i]  = {cap[i][14:0], qo[i]};
          ncap[i] = ncap[i] + 1;
        end
        if (dn[i]) ndone[i] = ndone[i] + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_caps();
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; ncap[i] = 0; ndone[i] = 0;
    end
  endtask

  task automatic expect_stream(input string name, input int i, input logic [15:0] bits,
                               input int nbits, input int ndn);
    check({name, "_bits"}, 32'(cap[i]), 32'(bits));
    check({name, "_nbits"}, 32'(ncap[i]), 32'(nbits));
    check({name, "_ndone"}, 32'(ndone[i]), 32'(ndn));
  endtask

  initial begin
    reset = 1'b1;
    din   = '0;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0; se[i] = 1'b0;
    end
    clr_caps();
    step();
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_u%0d", i), 32'({qv[i], qo[i], dn[i], lr[i]}), 32'(4'b0001));
    reset = 1'b0;
    step();

    // MSB first 1010 with shift_en held high
    clr_caps();
    lv[0] = 1'b1; din = 8'h0A; se[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    repeat (6) step();
    se[0] = 1'b0;
    expect_stream("msb_1010", 0, 16'h000A, 4, 1);

    // LSB first 0010 -> 0,1,0,0
    clr_caps();
    lv[1] = 1'b1; din = 8'h02; se[1] = 1'b1;
    step();
    lv[1] = 1'b0;
    repeat (6) step();
    se[1] = 1'b0;
    expect_stream("lsb_0010", 1, 16'h0004, 4, 1);

    // Back-to-back 0110 then 0001 loaded on the last bit
    clr_caps();
    lv[0] = 1'b1; din = 8'h06; se[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    repeat (3) step();
    check("b2b_ready_at_last", 32'(lr[0]), 32'(1));
    lv[0] = 1'b1; din = 8'h01;
    step();
    lv[0] = 1'b0;
    check("b2b_no_gap", 32'(qv[0]), 32'(1));
    repeat (5) step();
    se[0] = 1'b0;
    expect_stream("b2b", 0, 16'h0061, 8, 2);

    // Stall pattern 1,0,0,1,1,1 with a mid-word load attempt
    clr_caps();
    lv[0] = 1'b1; din = 8'h0C; se[0] = 1'b0;
    step();
    lv[0] = 1'b0; se[0] = 1'b1;
    step();
    lv[0] = 1'b1; din = 8'h03; se[0] = 1'b0;
    step();
    lv[0] = 1'b0;
    check("stall_hold_q", 32'(qo[0]), 32'(1));
    step();
    se[0] = 1'b1;
    repeat (3) step();
    se[0] = 1'b0;
    repeat (2) step();
    expect_stream("stall", 0, 16'h000C, 4, 1);

    // Reset after two of four bits, then a full 1111 word
    clr_caps();
    lv[0] = 1'b1; din = 8'h0A; se[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    repeat (2) step();
    reset = 1'b1; lv[0] = 1'b1; din = 8'h00;
    step();
    reset = 1'b0; lv[0] = 1'b0; se[0] = 1'b0;
    check("abort_outputs", 32'({qv[0], dn[0], lr[0]}), 32'(3'b001));
    check("abort_no_done", 32'(ndone[0]), 32'(0));
    step();
    clr_caps();
    lv[0] = 1'b1; din = 8'h0F; se[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    repeat (5) step();
    se[0] = 1'b0;
    expect_stream("after_reset", 0, 16'h000F, 4, 1);

    // Width 8, MSB first, A5
    clr_caps();
    lv[2] = 1'b1; din = 8'hA5; se[2] = 1'b1;
    step();
    lv[2] = 1'b0;
    repeat (10) step();
    se[2] = 1'b0;
    expect_stream("w8_a5", 2, 16'h00A5, 8, 1);

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
